// File: rtl/core_debug_unit_pkg.sv
// Shared definitions for the core debug unit: host command op codes,
// halt-cause codes, controller state encoding and the default datapath width.
package core_debug_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NUM_BP_MAX   = 16;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_HALT     = 3'd1,
    OP_RUN      = 3'd2,
    OP_STEP     = 3'd3,
    OP_SET_BP   = 3'd4,
    OP_CLR_BP   = 3'd5,
    OP_READ_REG = 3'd6,
    OP_READ_CNT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_HOST  = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_STEP  = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2,
    ST_RDREG  = 2'd3
  } state_e;

  // True when a host-supplied index addresses an implemented comparator.
  function automatic logic bp_idx_ok(input logic [4:0] idx, input int unsigned nbp);
    return 32'(idx) < nbp;
  endfunction

endpackage

// File: rtl/core_debug_unit_bp_match.sv
// PC breakpoint bank: NUM_BP address/enable registers and the comparator
// OR tree.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_en_i            write comparator wr_idx_i this cycle
//   wr_set_i           1: load wr_addr_i and enable; 0: disable
//   wr_idx_i           comparator index (caller guarantees < NUM_BP)
//   wr_addr_i          breakpoint address
//   pc_i               current core PC
//   hit_o              some enabled comparator matches pc_i
module bp_match
  import core_debug_unit_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NUM_BP = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic            wr_set_i,
  input  logic [4:0]      wr_idx_i,
  input  logic [XLEN-1:0] wr_addr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            hit_o
);

  logic [XLEN-1:0]   addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= '0;
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        if (wr_idx_i == 5'(i)) begin
          en_q[i] <= wr_set_i;
          if (wr_set_i) begin
            addr_q[i] <= wr_addr_i;
          end
        end
      end
    end
  end

  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (en_q[i] && (addr_q[i] == pc_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_debug_unit.sv
// Run-control and inspection unit between a host debug port and a
// single-cycle core. Gates the core clock-enable for halt/run/step and PC
// breakpoints, reads core registers through the debug select, and counts
// enabled core cycles.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid/ready/op/idx/arg host command channel
//   rsp_valid/ready/data/err   host response channel (held until taken)
//   core_en                    core may advance this cycle
//   core_pc                    current core PC
//   core_dbg_sel/dbg_data      core debug register select / value
//   halted, halt_cause         run status and reason for last halt
module core_debug_unit
  import core_debug_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned NUM_BP     = 4,
  parameter bit          RESET_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [4:0]      cmd_idx,
  input  logic [XLEN-1:0] cmd_arg,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            core_en,
  input  logic [XLEN-1:0] core_pc,
  output logic [4:0]      core_dbg_sel,
  input  logic [XLEN-1:0] core_dbg_data,
  output logic            halted,
  output logic [1:0]      halt_cause
);

  localparam state_e RST_STATE = RESET_HALT ? ST_HALTED : ST_RUN;

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d;
  logic            skip_q, skip_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_pc_q, rsp_pc_d;
  logic [4:0]      dbg_sel_q, dbg_sel_d;
  logic [XLEN-1:0] count_q, count_d;

  op_e  op;
  logic accept;
  logic bp_hit;
  logic bp_we;
  logic bp_set;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = !rsp_valid_q && ((state_q == ST_RUN) || (state_q == ST_HALTED));
  assign accept    = cmd_valid && cmd_ready;
  assign core_en   = ((state_q == ST_RUN) && !(bp_hit && !skip_q)) || (state_q == ST_STEP);
  assign bp_set    = (op == OP_SET_BP);
  assign count_d   = count_q + {{(XLEN-1){1'b0}}, core_en};

  bp_match #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (bp_we),
    .wr_set_i  (bp_set),
    .wr_idx_i  (cmd_idx),
    .wr_addr_i (cmd_arg),
    .pc_i      (core_pc),
    .hit_o     (bp_hit)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    skip_d      = skip_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_pc_d    = rsp_pc_q;
    dbg_sel_d   = dbg_sel_q;
    bp_we       = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_pc_d    = 1'b0;
      if (rsp_pc_q) begin
        rsp_data_d = core_pc;
      end
    end

    case (state_q)
      ST_RUN: begin
        skip_d = 1'b0;
        if (bp_hit && !skip_q) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end
      end
      ST_STEP: begin
        state_d     = ST_HALTED;
        cause_d     = CAUSE_STEP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_pc_d    = 1'b1;
      end
      ST_RDREG: begin
        state_d     = ST_HALTED;
        rsp_valid_d = 1'b1;
        rsp_data_d  = core_dbg_data;
        rsp_err_d   = 1'b0;
        rsp_pc_d    = 1'b0;
      end
      default: ;
    endcase

    // Accepted commands override the breakpoint halt above, so a HALT in the
    // same cycle as a hit reports cause HOST and still responds.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;
      rsp_pc_d    = 1'b0;
      case (op)
        OP_HALT: begin
          state_d  = ST_HALTED;
          cause_d  = CAUSE_HOST;
          rsp_pc_d = 1'b1;
        end
        OP_RUN: begin
          if (state_q == ST_HALTED) begin
            state_d = ST_RUN;
            skip_d  = 1'b1;
          end
        end
        OP_STEP: begin
          if (state_q == ST_HALTED) begin
            state_d     = ST_STEP;
            rsp_valid_d = 1'b0;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_SET_BP, OP_CLR_BP: begin
          if (bp_idx_ok(cmd_idx, NUM_BP)) begin
            bp_we = 1'b1;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_READ_REG: begin
          if (state_q == ST_HALTED) begin
            dbg_sel_d   = cmd_idx;
            state_d     = ST_RDREG;
            rsp_valid_d = 1'b0;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_READ_CNT: rsp_data_d = count_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST_STATE;
      cause_q     <= CAUSE_RESET;
      skip_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_pc_q    <= 1'b0;
      dbg_sel_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      skip_q      <= skip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_pc_q    <= rsp_pc_d;
      dbg_sel_q   <= dbg_sel_d;
      count_q     <= count_d;
    end
  end

  // HALT/STEP report the PC after the core has stopped. That PC is only known
  // after the edge that ends the last enabled cycle, and the core stays frozen
  // while the response is pending, so the live PC is forwarded until hand-off.
  assign rsp_data     = rsp_pc_q ? core_pc : rsp_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign core_dbg_sel = dbg_sel_q;
  assign halted       = (state_q == ST_HALTED) || (state_q == ST_RDREG);
  assign halt_cause   = cause_q;

endmodule

// File: tb/tb_core_debug_unit.sv
module tb_core_debug_unit;

  localparam logic [2:0] OP_NOP = 3'd0, OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3,
                         OP_SET = 3'd4, OP_CLR = 3'd5, OP_RREG = 3'd6, OP_RCNT = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        core_en;
  logic [31:0] core_pc;
  logic [4:0]  core_dbg_sel;
  logic [31:0] core_dbg_data;
  logic        halted;
  logic [1:0]  halt_cause;

  core_debug_unit #(.XLEN(32), .NUM_BP(4), .RESET_HALT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_en(core_en), .core_pc(core_pc), .core_dbg_sel(core_dbg_sel), .core_dbg_data(core_dbg_data),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple core: PC advances by 4 per enabled cycle; register file read combinationally.
  logic [31:0] pc_r;
  logic [31:0] regs [32];
  assign core_pc       = pc_r;
  assign core_dbg_data = regs[core_dbg_sel];
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_r <= '0;
    else if (core_en) pc_r <= pc_r + 32'd4;
  end

  // Transaction-level reference model.
  logic [31:0] m_pc, m_cnt;
  logic [31:0] m_bp_addr [4];
  logic        m_bp_en [4];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc = '0;
    m_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      m_bp_en[i] = 1'b0;
      m_bp_addr[i] = '0;
    end
  endfunction

  // Cycles of running (j >= 1) before the PC first lands on an enabled breakpoint.
  function automatic int unsigned first_bp(input logic [31:0] p0);
    for (int unsigned j = 1; j <= 64; j++)
      for (int i = 0; i < 4; i++)
        if (m_bp_en[i] && m_bp_addr[i] == p0 + 32'(4 * j)) return j;
    return 1000;
  endfunction

  // Called at a negedge; returns at a negedge after the response is taken.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] idx, input logic [31:0] arg,
                        output logic [31:0] data, output logic err, output int unsigned acc);
    int unsigned k;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_arg = arg;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    data = rsp_data;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_cause"}, 32'(halt_cause), 32'd0);
    check({tag, "_core_en"}, 32'(core_en), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_dbg_sel"}, 32'(core_dbg_sel), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_then_halt(input int unsigned w);
    logic [31:0] d;
    logic e;
    int unsigned e0, eh, jb, n;
    jb = first_bp(m_pc);
    do_cmd(OP_RUN, 5'd0, '0, d, e, e0);
    check("run_data", d, 32'd0);
    check("run_err", 32'(e), 32'd0);
    repeat (w) @(negedge clk);
    do_cmd(OP_HALT, 5'd0, '0, d, e, eh);
    n = eh - e0;
    if (jb < n) n = jb;
    m_pc = m_pc + 32'(4 * n);
    m_cnt = m_cnt + 32'(n);
    check("halt_pc", d, m_pc);
    check("halt_err", 32'(e), 32'd0);
    check("halt_cause", 32'(halt_cause), 32'd1);
    check("halt_halted", 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  idx;
    logic [31:0] arg;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] d, bpa;
    logic e;
    int unsigned acc, e0, eh, jb, n, k, r, idx;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'hDEADBEEF;
    regs[3] = 32'h12345678;
    model_reset();

    vecs[0] = '{OP_NOP,  5'd0, 32'h0,  32'h0,        1'b0};
    vecs[1] = '{OP_RCNT, 5'd0, 32'h0,  32'h0,        1'b0};
    vecs[2] = '{OP_RREG, 5'd5, 32'h0,  32'hDEADBEEF, 1'b0};
    vecs[3] = '{OP_RREG, 5'd3, 32'h0,  32'h12345678, 1'b0};
    vecs[4] = '{OP_SET,  5'd7, 32'h40, 32'h0,        1'b1};
    vecs[5] = '{OP_CLR,  5'd4, 32'h0,  32'h0,        1'b1};
    vecs[6] = '{OP_SET,  5'd0, 32'h8,  32'h0,        1'b0};
    vecs[7] = '{OP_CLR,  5'd0, 32'h0,  32'h0,        1'b0};
    vecs[8] = '{OP_SET,  5'd1, 32'h10, 32'h0,        1'b0};
    vecs[9] = '{OP_HALT, 5'd0, 32'h0,  32'h0,        1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    for (int i = 0; i < 10; i++) begin
      do_cmd(vecs[i].op, vecs[i].idx, vecs[i].arg, d, e, acc);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end
    check("halt_while_halted_cause", 32'(halt_cause), 32'd1);
    m_bp_en[1] = 1'b1;
    m_bp_addr[1] = 32'h10;

    // RUN from PC 0 into the breakpoint at 0x10.
    do_cmd(OP_RUN, 5'd0, '0, d, e, e0);
    check("runA_data", d, 32'd0);
    check("runA_core_en", 32'(core_en), 32'd1);
    check("runA_running", 32'(halted), 32'd0);
    k = 0;
    while (!halted && k < 100) begin @(negedge clk); k++; end
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_pc", core_pc, 32'h10);
    check("bp_cause", 32'(halt_cause), 32'd2);
    check("bp_core_en", 32'(core_en), 32'd0);
    m_pc = 32'h10;
    m_cnt = 32'd4;
    do_cmd(OP_RCNT, 5'd0, '0, d, e, acc);
    check("bp_count", d, 32'd4);

    // Resume from the breakpoint address: must move past it.
    run_then_halt(5);

    // STEP: exactly one enabled cycle.
    check("step_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_idx = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("step_t1_en", 32'(core_en), 32'd1);
    check("step_t1_halted", 32'(halted), 32'd0);
    check("step_t1_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    m_pc = m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    check("step_t2_en", 32'(core_en), 32'd0);
    check("step_t2_halted", 32'(halted), 32'd1);
    check("step_t2_rsp", 32'(rsp_valid), 32'd1);
    check("step_t2_data", rsp_data, m_pc);
    check("step_t2_cause", 32'(halt_cause), 32'd3);
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;

    // STEP and READ_REG while running are rejected.
    jb = first_bp(m_pc);
    do_cmd(OP_RUN, 5'd0, '0, d, e, e0);
    do_cmd(OP_STEP, 5'd0, '0, d, e, acc);
    check("step_running_err", 32'(e), 32'd1);
    do_cmd(OP_RREG, 5'd5, '0, d, e, acc);
    check("rreg_running_err", 32'(e), 32'd1);
    do_cmd(OP_HALT, 5'd0, '0, d, e, eh);
    n = eh - e0;
    if (jb < n) n = jb;
    m_pc = m_pc + 32'(4 * n);
    m_cnt = m_cnt + 32'(n);
    check("mid_halt_pc", d, m_pc);

    // READ_REG timing.
    cmd_valid = 1'b1; cmd_op = OP_RREG; cmd_idx = 5'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rr_t1_sel", 32'(core_dbg_sel), 32'd5);
    check("rr_t1_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rr_t2_rsp", 32'(rsp_valid), 32'd1);
    check("rr_t2_data", rsp_data, 32'hDEADBEEF);
    check("rr_t2_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;

    // HALT accepted in the very cycle the breakpoint matches.
    bpa = m_pc + 32'd16;
    do_cmd(OP_SET, 5'd2, bpa, d, e, acc);
    m_bp_en[2] = 1'b1;
    m_bp_addr[2] = bpa;
    jb = first_bp(m_pc);
    do_cmd(OP_RUN, 5'd0, '0, d, e, e0);
    repeat (3) @(negedge clk);
    check("sync_pc_at_bp", core_pc, bpa);
    check("sync_core_en", 32'(core_en), 32'd0);
    check("sync_not_halted", 32'(halted), 32'd0);
    do_cmd(OP_HALT, 5'd0, '0, d, e, eh);
    n = eh - e0;
    if (jb < n) n = jb;
    m_pc = m_pc + 32'(4 * n);
    m_cnt = m_cnt + 32'(n);
    check("sync_data", d, bpa);
    check("sync_model_pc", d, m_pc);
    check("sync_cause", 32'(halt_cause), 32'd1);

    // Response back-pressure.
    cmd_valid = 1'b1; cmd_op = OP_RCNT;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", rsp_data, m_cnt);
      check("bp_hold_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    check("handoff_ready", 32'(cmd_ready), 32'd1);
    check("handoff_valid", 32'(rsp_valid), 32'd0);

    // Reset with a response pending.
    cmd_valid = 1'b1; cmd_op = OP_NOP;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pend_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("pend_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset during RDREG, then confirm breakpoints were cleared.
    do_cmd(OP_SET, 5'd3, 32'h14, d, e, acc);
    check("set3_err", 32'(e), 32'd0);
    cmd_valid = 1'b1; cmd_op = OP_RREG; cmd_idx = 5'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rdreg_sel", 32'(core_dbg_sel), 32'd3);
    reset = 1'b0;
    #1;
    check_reset_vals("rdreg_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    do_cmd(OP_RCNT, 5'd0, '0, d, e, acc);
    check("cnt_after_reset", d, 32'd0);
    run_then_halt(8);
    check("bp_cleared_pc", m_pc, 32'h28);

    // Randomized command mix against the model.
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: begin
          do_cmd(OP_NOP, 5'd0, '0, d, e, acc);
          check("r_nop", d, 32'd0);
          check("r_nop_err", 32'(e), 32'd0);
        end
        1: begin
          idx = $urandom_range(0, 7);
          bpa = m_pc + 32'(4 * $urandom_range(1, 12));
          do_cmd(OP_SET, 5'(idx), bpa, d, e, acc);
          check("r_set_err", 32'(e), (idx >= 4) ? 32'd1 : 32'd0);
          if (idx < 4) begin
            m_bp_en[idx] = 1'b1;
            m_bp_addr[idx] = bpa;
          end
        end
        2: begin
          idx = $urandom_range(0, 7);
          do_cmd(OP_CLR, 5'(idx), '0, d, e, acc);
          check("r_clr_err", 32'(e), (idx >= 4) ? 32'd1 : 32'd0);
          if (idx < 4) m_bp_en[idx] = 1'b0;
        end
        3: begin
          idx = $urandom_range(0, 31);
          do_cmd(OP_RREG, 5'(idx), '0, d, e, acc);
          check("r_rreg", d, regs[idx]);
          check("r_rreg_err", 32'(e), 32'd0);
        end
        4: begin
          do_cmd(OP_RCNT, 5'd0, '0, d, e, acc);
          check("r_cnt", d, m_cnt);
        end
        5: begin
          do_cmd(OP_STEP, 5'd0, '0, d, e, acc);
          m_pc = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
          check("r_step", d, m_pc);
          check("r_step_cause", 32'(halt_cause), 32'd3);
        end
        6: begin
          do_cmd(OP_HALT, 5'd0, '0, d, e, acc);
          check("r_halt", d, m_pc);
          check("r_halt_cause", 32'(halt_cause), 32'd1);
        end
        default: run_then_halt($urandom_range(0, 15));
      endcase
      check("r_core_en_idle", 32'(core_en), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
